grf_mp: RTL



---
 rtl/grf_pkg.sv | 12 +
 rtl/grf_rd_port.sv | 38 +++
 rtl/grf_mp.sv | 81 ++++++++
 3 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared defaults, zero-register constant and packed-slice helper for the multi-port GRF
package grf_pkg;
    localparam int DW_DEF    = 32;
    localparam int AW_DEF    = 5;
    localparam int MAX_RD    = 4;
    localparam int MAX_WR    = 2;
    localparam int ZERO_ADDR = 0;

    function automatic int lo(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/grf_rd_port.sv
// grf_rd_port: one read port with write-through bypass, zero-register forcing and busy masking
module grf_rd_port
    import grf_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int NUM_WR = 1
) (
    input  logic                 reset,
    input  logic [AW-1:0]        rd_addr,
    input  logic [DW-1:0]        reg_data,
    input  logic                 reg_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_busy
);
    logic          hit;
    logic [DW-1:0] byp;
    logic          zero;

    assign zero = rd_addr == AW'(ZERO_ADDR);

    // ascending scan so the highest-index matching write port is the one forwarded
    always_comb begin
        hit = 1'b0;
        byp = '0;
        for (int j = 0; j < NUM_WR; j++)
            if (!reset && wr_en[j] && wr_addr[lo(j, AW) +: AW] == rd_addr) begin
                hit = 1'b1;
                byp = wr_data[lo(j, DW) +: DW];
            end
    end

    assign rd_data = zero ? '0 : hit ? byp : reg_data;
    assign rd_busy = !zero && reg_busy && !hit;
endmodule

// File: rtl/grf_mp.sv
// grf_mp: multi-port register file with busy scoreboard; define GRF_TRACE_EN to print stored writes
module grf_mp
    import grf_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_busy,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic [NUM_WR*32-1:0] wr_pc,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy;

    // later ports overwrite earlier ones; an issue lands last so set beats clear
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (wr_en[j] && wr_addr[lo(j, AW) +: AW] != AW'(ZERO_ADDR)) begin
                    regs[wr_addr[lo(j, AW) +: AW]] <= wr_data[lo(j, DW) +: DW];
                    busy[wr_addr[lo(j, AW) +: AW]] <= 1'b0;
                end
            if (iss_en && iss_addr != AW'(ZERO_ADDR)) busy[iss_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        grf_rd_port #(.DW(DW), .AW(AW), .NUM_WR(NUM_WR)) u_port (
            .reset   (reset),
            .rd_addr (rd_addr[lo(k, AW) +: AW]),
            .reg_data(regs[rd_addr[lo(k, AW) +: AW]]),
            .reg_busy(busy[rd_addr[lo(k, AW) +: AW]]),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[lo(k, DW) +: DW]),
            .rd_busy (rd_busy[k])
        );
    end

`ifdef GRF_TRACE_EN
    logic [NUM_WR-1:0] wins;

    // a port wins unless a higher port writes the same address this cycle
    always_comb begin
        wins = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wins[j] = wr_en[j] && wr_addr[lo(j, AW) +: AW] != AW'(ZERO_ADDR);
            for (int m = j + 1; m < NUM_WR; m++)
                if (wr_en[m] && wr_addr[lo(m, AW) +: AW] == wr_addr[lo(j, AW) +: AW]) wins[j] = 1'b0;
        end
    end

    // one trace line per stored write, ascending port order
    always @(posedge clk) begin
        if (!reset)
            for (int j = 0; j < NUM_WR; j++)
                if (wins[j])
                    $display("%d@%h: $%d <= %h", $time, wr_pc[lo(j, 32) +: 32],
                             wr_addr[lo(j, AW) +: AW], wr_data[lo(j, DW) +: DW]);
    end
`else
    logic unused_pc;
    assign unused_pc = ^wr_pc;
`endif
endmodule
